// File: rtl/image_mem_pkg.sv
// Shared constants, state and tag encodings for the image memory arbiter.
// Also holds the address range check used by both ports.
package image_mem_pkg;

  localparam int DEPTH      = 784;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_DISP = 2'b01,
    TAG_NN   = 2'b10
  } rd_tag_e;

  typedef struct packed {
    rd_tag_e tag;
    logic    oor;
  } rd_slot_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr < ADDR_W'(DEPTH));
  endfunction

endpackage

// File: rtl/image_mem_arbiter_if.sv
// Requester, grant, read-return and image-memory port bundle.
// slave = arbiter side, master = requesters plus memory.
interface image_mem_arbiter_if;
  import image_mem_pkg::*;

  logic              clear_req;
  logic              nn_lock;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              nn_req;
  logic [ADDR_W-1:0] nn_addr;
  logic              wr_gnt;
  logic              disp_gnt;
  logic              nn_gnt;
  logic              disp_rvalid;
  logic              nn_rvalid;
  logic [DATA_W-1:0] rd_data;
  logic              clear_busy;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  clear_req, nn_lock, wr_req, wr_addr, wr_data,
           disp_req, disp_addr, nn_req, nn_addr, mem_data_out,
    output wr_gnt, disp_gnt, nn_gnt, disp_rvalid, nn_rvalid, rd_data,
           clear_busy, mem_write_addr, mem_data_in, mem_we, mem_read_addr
  );

  modport master (
    output clear_req, nn_lock, wr_req, wr_addr, wr_data,
           disp_req, disp_addr, nn_req, nn_addr, mem_data_out,
    input  wr_gnt, disp_gnt, nn_gnt, disp_rvalid, nn_rvalid, rd_data,
           clear_busy, mem_write_addr, mem_data_in, mem_we, mem_read_addr
  );

endinterface

// File: rtl/image_rd_arbiter.sv
// Read-side arbiter: inference reads win unless the display has been
// denied STARVE_MAX cycles in a row.
module image_rd_arbiter
  import image_mem_pkg::*;
(
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic disp_req,
  input  logic nn_req,
  output logic disp_gnt,
  output logic nn_gnt
);

  logic [STARVE_W-1:0] starve_r;
  logic                disp_win_s;

  // Display wins when inference is idle or the display has hit its starvation limit.
  always_comb begin
    disp_win_s = 1'b0;
    if (!resetn) begin
      disp_win_s = 1'b0;
    end else if (disp_req && (!nn_req || (starve_r == STARVE_W'(STARVE_MAX)))) begin
      disp_win_s = 1'b1;
    end else begin
      disp_win_s = 1'b0;
    end
  end

  assign disp_gnt = disp_win_s;
  assign nn_gnt   = nn_req & resetn & ~disp_win_s;

  // Count consecutive display denials, saturating at the limit.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      starve_r <= '0;
    end else if (disp_win_s) begin
      starve_r <= '0;
    end else if (disp_req && (starve_r != STARVE_W'(STARVE_MAX))) begin
      starve_r <= starve_r + STARVE_W'(1);
    end else begin
      starve_r <= starve_r;
    end
  end

endmodule

// File: rtl/image_mem_arbiter.sv
// Image memory arbiter: pen writes, whole-image clear sweep, and
// display/inference reads sharing one synchronous image memory.
module image_mem_arbiter
  import image_mem_pkg::*;
(
  input logic                CLOCK_50,
  input logic                resetn,
  image_mem_arbiter_if.slave bus
);

  clr_state_e        state_r;
  logic [ADDR_W-1:0] count_r;
  logic              pending_r;
  logic              clear_pend_s;
  logic              wr_gnt_s;
  logic              disp_gnt_s;
  logic              nn_gnt_s;
  logic [ADDR_W-1:0] rd_addr_s;
  rd_slot_t          slot_in_s;
  rd_slot_t          slot1_r;
  rd_slot_t          slot2_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_write_addr_r;
  logic [DATA_W-1:0] mem_data_in_r;
  logic [ADDR_W-1:0] mem_read_addr_r;

  // A clear request seen in IDLE counts as pending in its own cycle, blocking writes.
  always_comb begin
    clear_pend_s = pending_r;
    wr_gnt_s     = 1'b0;
    if (state_r == ST_IDLE) begin
      clear_pend_s = pending_r | bus.clear_req;
    end else begin
      clear_pend_s = pending_r;
    end
    if (resetn && bus.wr_req && (state_r == ST_IDLE) && !bus.nn_lock && !clear_pend_s) begin
      wr_gnt_s = 1'b1;
    end else begin
      wr_gnt_s = 1'b0;
    end
  end

  // Clear FSM; once started the sweep runs to the last word regardless of nn_lock.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      count_r   <= '0;
      pending_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          count_r <= '0;
          if (clear_pend_s && !bus.nn_lock) begin
            state_r   <= ST_CLEAR;
            pending_r <= 1'b0;
          end else begin
            state_r   <= ST_IDLE;
            pending_r <= clear_pend_s;
          end
        end
        ST_CLEAR: begin
          pending_r <= 1'b0;
          if (count_r == ADDR_W'(DEPTH - 1)) begin
            state_r <= ST_IDLE;
            count_r <= '0;
          end else begin
            state_r <= ST_CLEAR;
            count_r <= count_r + ADDR_W'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          count_r   <= '0;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  // Registered memory write port: sweep words, or the granted pen write.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      mem_we_r         <= 1'b0;
      mem_write_addr_r <= '0;
      mem_data_in_r    <= '0;
    end else if (state_r == ST_CLEAR) begin
      mem_we_r         <= 1'b1;
      mem_write_addr_r <= count_r;
      mem_data_in_r    <= '0;
    end else if (wr_gnt_s) begin
      mem_we_r         <= addr_in_range(bus.wr_addr);
      mem_write_addr_r <= bus.wr_addr;
      mem_data_in_r    <= bus.wr_data;
    end else begin
      mem_we_r         <= 1'b0;
      mem_write_addr_r <= '0;
      mem_data_in_r    <= '0;
    end
  end

  image_rd_arbiter u_rd_arb (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .disp_req (bus.disp_req),
    .nn_req   (bus.nn_req),
    .disp_gnt (disp_gnt_s),
    .nn_gnt   (nn_gnt_s)
  );

  // Pick the granted read address and the tag that travels with it.
  always_comb begin
    rd_addr_s = '0;
    slot_in_s = '{tag: TAG_NONE, oor: 1'b0};
    if (nn_gnt_s) begin
      rd_addr_s = bus.nn_addr;
      slot_in_s = '{tag: TAG_NN, oor: !addr_in_range(bus.nn_addr)};
    end else if (disp_gnt_s) begin
      rd_addr_s = bus.disp_addr;
      slot_in_s = '{tag: TAG_DISP, oor: !addr_in_range(bus.disp_addr)};
    end else begin
      rd_addr_s = '0;
      slot_in_s = '{tag: TAG_NONE, oor: 1'b0};
    end
  end

  // Read address register plus the two-stage tag pipeline matching memory latency.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      mem_read_addr_r <= '0;
      slot1_r         <= '{tag: TAG_NONE, oor: 1'b0};
      slot2_r         <= '{tag: TAG_NONE, oor: 1'b0};
    end else begin
      if (slot_in_s.tag != TAG_NONE) begin
        mem_read_addr_r <= rd_addr_s;
      end else begin
        mem_read_addr_r <= mem_read_addr_r;
      end
      slot1_r <= slot_in_s;
      slot2_r <= slot1_r;
    end
  end

  assign bus.wr_gnt         = wr_gnt_s;
  assign bus.disp_gnt       = disp_gnt_s;
  assign bus.nn_gnt         = nn_gnt_s;
  assign bus.clear_busy     = (state_r == ST_CLEAR);
  assign bus.mem_we         = mem_we_r;
  assign bus.mem_write_addr = mem_write_addr_r;
  assign bus.mem_data_in    = mem_data_in_r;
  assign bus.mem_read_addr  = mem_read_addr_r;
  assign bus.disp_rvalid    = (slot2_r.tag == TAG_DISP);
  assign bus.nn_rvalid      = (slot2_r.tag == TAG_NN);
  assign bus.rd_data        = ((slot2_r.tag != TAG_NONE) && !slot2_r.oor) ? bus.mem_data_out : '0;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Bench for image_mem_arbiter: directed stimulus, an abstract per-cycle
// model with a read-return schedule, and literal spot checks.
module tb_image_mem_arbiter;
  import image_mem_pkg::*;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  logic init_mem = 1'b1;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  image_mem_arbiter_if bif ();

  image_mem_arbiter dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bif)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Image memory with one-cycle synchronous read; out-of-range reads return junk.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge CLOCK_50) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= (i == 10) ? 32'd5 : 32'd0;
    end else if (bif.mem_we && (int'(bif.mem_write_addr) < DEPTH)) begin
      mem[int'(bif.mem_write_addr)] <= bif.mem_data_in;
    end
    if (int'(bif.mem_read_addr) < DEPTH) bif.mem_data_out <= mem[int'(bif.mem_read_addr)];
    else bif.mem_data_out <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- abstract model ----------------
  int unsigned       cyc = 0;
  int                m_left, m_caddr, m_starve;
  bit                m_pend, m_we;
  logic [ADDR_W-1:0] m_waddr, m_raddr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] shadow [DEPTH];
  int                sched_kind [int unsigned];
  logic [DATA_W-1:0] sched_data [int unsigned];

  task automatic model_reset();
    m_left = 0; m_caddr = 0; m_starve = 0; m_pend = 0; m_we = 0;
    m_waddr = '0; m_wdata = '0; m_raddr = '0;
    sched_kind.delete();
    sched_data.delete();
  endtask

  task automatic model_step();
    bit busy, pend, e_wg, e_dg, e_ng;
    int e_kind, a;
    logic [DATA_W-1:0] e_data;
    busy = (m_left > 0);
    pend = m_pend || (bif.clear_req && !busy);
    e_wg = bif.wr_req && !busy && !bif.nn_lock && !pend;
    e_dg = bif.disp_req && (!bif.nn_req || (m_starve >= STARVE_MAX));
    e_ng = bif.nn_req && !e_dg;
    chk("wr_gnt", bif.wr_gnt, e_wg);
    chk("disp_gnt", bif.disp_gnt, e_dg);
    chk("nn_gnt", bif.nn_gnt, e_ng);
    chk("clear_busy", bif.clear_busy, busy);
    chk("mem_we", bif.mem_we, m_we);
    if (m_we) begin
      chk("mem_write_addr", bif.mem_write_addr, m_waddr);
      chk("mem_data_in", bif.mem_data_in, m_wdata);
    end
    chk("mem_read_addr", bif.mem_read_addr, m_raddr);
    e_kind = sched_kind.exists(cyc) ? sched_kind[cyc] : 0;
    e_data = sched_data.exists(cyc) ? sched_data[cyc] : '0;
    chk("disp_rvalid", bif.disp_rvalid, e_kind == 1);
    chk("nn_rvalid", bif.nn_rvalid, e_kind == 2);
    chk("rd_data", bif.rd_data, e_data);
    if (sched_kind.exists(cyc)) begin
      sched_kind.delete(cyc);
      sched_data.delete(cyc);
    end
    // reads see memory contents from before this cycle's writes
    if (e_dg || e_ng) begin
      a = e_ng ? int'(bif.nn_addr) : int'(bif.disp_addr);
      m_raddr = ADDR_W'(a);
      sched_kind[cyc + 2] = e_ng ? 2 : 1;
      sched_data[cyc + 2] = (a < DEPTH) ? shadow[a] : '0;
    end
    if (e_dg) m_starve = 0;
    else if (bif.disp_req && (m_starve < STARVE_MAX)) m_starve++;
    if (busy) begin
      m_we = 1; m_waddr = ADDR_W'(m_caddr); m_wdata = '0;
      shadow[m_caddr] = '0;
      m_caddr++; m_left--; m_pend = 0;
    end else begin
      if (pend && !bif.nn_lock) begin
        m_left = DEPTH; m_caddr = 0; m_pend = 0;
      end else begin
        m_pend = pend;
      end
      m_we = e_wg && (int'(bif.wr_addr) < DEPTH);
      if (m_we) begin
        m_waddr = bif.wr_addr; m_wdata = bif.wr_data;
        shadow[int'(bif.wr_addr)] = bif.wr_data;
      end
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    shadow[10] = 32'd5;
    model_reset();
    forever begin
      @(negedge CLOCK_50);
      cyc++;
      if (!resetn) begin
        chk("rst_wr_gnt", bif.wr_gnt, 1'b0);
        chk("rst_disp_gnt", bif.disp_gnt, 1'b0);
        chk("rst_nn_gnt", bif.nn_gnt, 1'b0);
        chk("rst_rvalid", {bif.disp_rvalid, bif.nn_rvalid}, 2'b00);
        chk("rst_busy_we", {bif.clear_busy, bif.mem_we}, 2'b00);
        chk("rst_rd_data", bif.rd_data, 32'd0);
        chk("rst_addrs", {bif.mem_write_addr, bif.mem_read_addr}, 32'd0);
        chk("rst_mem_data_in", bif.mem_data_in, 32'd0);
        model_reset();
      end else begin
        model_step();
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic mid();
    @(negedge CLOCK_50);
  endtask

  int busy_n, we_n, wg_n, ng, dg, rv_n, bad_n, first_a, last_a;
  logic [9:0] dmask;

  initial begin
    bif.clear_req = 1'b0; bif.nn_lock = 1'b0;
    bif.wr_req = 1'b1; bif.wr_addr = 16'd57; bif.wr_data = 32'd1;
    bif.disp_req = 1'b1; bif.disp_addr = 16'd57;
    bif.nn_req = 1'b1; bif.nn_addr = 16'd10;
    repeat (3) @(posedge CLOCK_50);
    #1;
    init_mem = 1'b0;
    mid();
    chk("reset_grants", {bif.wr_gnt, bif.disp_gnt, bif.nn_gnt}, 3'b000);
    nxt(); resetn = 1'b1; bif.wr_req = 1'b0; bif.disp_req = 1'b0; bif.nn_req = 1'b0;

    // pen write in range then out of range
    nxt(); bif.wr_req = 1'b1; bif.wr_addr = 16'd57; bif.wr_data = 32'd1;
    mid(); chk("wr57_gnt", bif.wr_gnt, 1'b1);
    nxt(); bif.wr_addr = 16'd800; bif.wr_data = 32'h1234;
    mid();
    chk("wr57_port", {bif.mem_we, bif.mem_write_addr, bif.mem_data_in}, {1'b1, 16'd57, 32'd1});
    chk("wr800_gnt", bif.wr_gnt, 1'b1);
    nxt(); bif.wr_req = 1'b0;
    mid(); chk("wr800_we", bif.mem_we, 1'b0);

    // inference reads: preloaded word and out-of-range address
    nxt(); bif.nn_req = 1'b1; bif.nn_addr = 16'd10;
    mid(); chk("nn10_gnt", bif.nn_gnt, 1'b1);
    nxt(); bif.nn_addr = 16'd900;
    mid(); chk("nn10_lat1", bif.nn_rvalid, 1'b0); chk("nn10_raddr", bif.mem_read_addr, 16'd10);
    nxt(); bif.nn_req = 1'b0;
    mid(); chk("nn10_rv", {bif.nn_rvalid, bif.rd_data}, {1'b1, 32'd5});
    nxt();
    mid(); chk("nn900_rv", {bif.nn_rvalid, bif.rd_data}, {1'b1, 32'd0});
    nxt();
    mid(); chk("nn_rv_done", {bif.nn_rvalid, bif.disp_rvalid}, 2'b00);

    // both readers held: four inference grants then one display grant
    nxt(); bif.nn_req = 1'b1; bif.disp_req = 1'b1; bif.disp_addr = 16'd57;
    ng = 0; dg = 0; rv_n = 0; dmask = '0;
    for (int i = 0; i < 10; i++) begin
      mid();
      ng += int'(bif.nn_gnt); dg += int'(bif.disp_gnt);
      dmask[i] = bif.disp_gnt;
      rv_n += int'(bif.nn_rvalid) + int'(bif.disp_rvalid);
      nxt();
    end
    bif.nn_req = 1'b0; bif.disp_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mid(); rv_n += int'(bif.nn_rvalid) + int'(bif.disp_rvalid); nxt();
    end
    chk("arb_nn_cnt", ng, 8);
    chk("arb_disp_cnt", dg, 2);
    chk("arb_pattern", dmask, 10'b10_0001_0000);
    chk("arb_rv_cnt", rv_n, 10);

    // full clear sweep with a write request held throughout
    bif.clear_req = 1'b1; bif.wr_req = 1'b1; bif.wr_addr = 16'd900;
    mid(); chk("clr_req_wgnt", bif.wr_gnt, 1'b0);
    nxt(); bif.clear_req = 1'b0;
    busy_n = 0; we_n = 0; wg_n = 0; first_a = -1; last_a = -1;
    for (int i = 0; i < 1000; i++) begin
      mid();
      busy_n += int'(bif.clear_busy);
      if (bif.clear_busy && bif.wr_gnt) wg_n++;
      if (bif.mem_we) begin
        we_n++;
        if (first_a < 0) first_a = int'(bif.mem_write_addr);
        last_a = int'(bif.mem_write_addr);
      end
      nxt();
    end
    chk("sweep_busy_cnt", busy_n, 784);
    chk("sweep_we_cnt", we_n, 784);
    chk("sweep_first_addr", first_a, 0);
    chk("sweep_last_addr", last_a, 783);
    chk("sweep_wgnt", wg_n, 0);
    bif.wr_req = 1'b1; bif.wr_addr = 16'd600; bif.wr_data = 32'd77;
    nxt(); bif.wr_req = 1'b0;

    // clear requested under nn_lock stays pending until the lock drops
    nxt(); bif.nn_lock = 1'b1; bif.clear_req = 1'b1;
    bif.wr_req = 1'b1; bif.wr_addr = 16'd57; bif.wr_data = 32'd9;
    mid(); chk("lock_wgnt", bif.wr_gnt, 1'b0);
    nxt(); bif.clear_req = 1'b0;
    bad_n = 0;
    for (int i = 0; i < 5; i++) begin
      mid(); bad_n += int'(bif.clear_busy) + int'(bif.wr_gnt); nxt();
    end
    chk("lock_hold", bad_n, 0);
    bif.nn_lock = 1'b0; bif.wr_req = 1'b0;
    mid(); chk("lock_release_busy", bif.clear_busy, 1'b0);
    nxt(); bif.nn_req = 1'b1; bif.nn_addr = 16'd600;
    mid(); chk("sweep2_start", bif.clear_busy, 1'b1); chk("clear_rd_gnt", bif.nn_gnt, 1'b1);
    nxt(); bif.nn_req = 1'b0; bif.nn_lock = 1'b1;
    mid();
    nxt();
    mid(); chk("clear_rd_data", {bif.nn_rvalid, bif.rd_data}, {1'b1, 32'd77});
    busy_n = 3;
    nxt();
    for (int i = 0; i < 1000; i++) begin
      mid(); busy_n += int'(bif.clear_busy); nxt();
    end
    chk("lock_sweep_cnt", busy_n, 784);
    bif.nn_lock = 1'b0;

    // reset in the middle of a sweep aborts it for good
    nxt(); bif.clear_req = 1'b1;
    mid();
    nxt(); bif.clear_req = 1'b0;
    for (int i = 0; i < 300; i++) begin
      mid();
      if (i == 299) chk("pre_rst_addr", {bif.clear_busy, bif.mem_write_addr}, {1'b1, 16'd298});
      nxt();
    end
    bif.wr_req = 1'b1; bif.nn_req = 1'b1; bif.disp_req = 1'b1; bif.disp_addr = 16'd5;
    resetn = 1'b0;
    #1;
    chk("rst_now_busy_we", {bif.clear_busy, bif.mem_we}, 2'b00);
    chk("rst_now_gnts", {bif.wr_gnt, bif.disp_gnt, bif.nn_gnt}, 3'b000);
    chk("rst_now_addrs", {bif.mem_write_addr, bif.mem_read_addr}, 32'd0);
    chk("rst_now_rd", {bif.disp_rvalid, bif.nn_rvalid, bif.rd_data}, 34'd0);
    nxt();
    nxt(); resetn = 1'b1; bif.wr_req = 1'b0; bif.nn_req = 1'b0; bif.disp_req = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      mid(); busy_n += int'(bif.clear_busy); nxt();
    end
    chk("no_resume", busy_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/image_mem_arbiter.md
IMAGE_MEM_ARBITER -- requirements
Module: image_mem_arbiter

Interface
REQ-001 Parameters SHALL be: DEPTH 784 (image words, 28x28); ADDR_W 16 (address width); DATA_W 32 (signed pixel word width); STARVE_MAX 4 (maximum consecutive display denials).
REQ-002 CLOCK_50  in  1  single system clock; all state SHALL update on its rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 clear_req  in  1  one-cycle pulse that requests a whole-image clear.
REQ-005 nn_lock  in  1  inference in progress; while high, image memory SHALL NOT be written.
REQ-006 wr_req / wr_addr / wr_data  in  1 / ADDR_W / DATA_W  pen-write requester.
REQ-007 disp_req / disp_addr  in  1 / ADDR_W  display-scan read requester.
REQ-008 nn_req / nn_addr  in  1 / ADDR_W  inference-engine read requester.
REQ-009 wr_gnt, disp_gnt, nn_gnt  out  1 each  same-cycle grants, combinational from registered state and inputs.
REQ-010 disp_rvalid, nn_rvalid  out  1 each  read-data-valid strobes.
REQ-011 rd_data  out  DATA_W  shared read data, qualified by the rvalid strobes.
REQ-012 clear_busy  out  1  high while the clear sweep is running.
REQ-013 mem_write_addr, mem_data_in, mem_we, mem_read_addr  out  ADDR_W / DATA_W / 1 / ADDR_W  registered image-memory port drives.
REQ-014 mem_data_out  in  DATA_W  image-memory read data, one-cycle synchronous read.

Function
REQ-015 Clear FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR when a clear is pending and nn_lock=0; CLEAR->IDLE after address DEPTH-1 is written.
REQ-016 A clear_req arriving while nn_lock=1 SHALL be latched as pending; a clear_req arriving in CLEAR SHALL be ignored.
REQ-017 In CLEAR, each cycle SHALL register mem_we=1, mem_write_addr=count, mem_data_in=0; count SHALL step 0..DEPTH-1 with no gaps.
REQ-018 wr_gnt = wr_req & state==IDLE & ~nn_lock & ~pending-clear.
REQ-019 A granted write SHALL appear on mem_we/mem_write_addr/mem_data_in on the next cycle.
REQ-020 A granted write with wr_addr>=DEPTH SHALL be granted but drive mem_we=0.
REQ-021 Read side: nn_req SHALL win by default; disp SHALL win when the starvation counter equals STARVE_MAX.
REQ-022 Starvation counter SHALL increment on each cycle disp_req is denied, clear on each disp grant, and saturate at STARVE_MAX.
REQ-023 Read sides SHALL be independent of the write side; reads SHALL be granted during CLEAR.
REQ-024 Granted read address SHALL register onto mem_read_addr on the next edge.
REQ-025 The matching rvalid SHALL assert for exactly one cycle, two cycles after the grant cycle; a 2-deep requester/out-of-range tag pipeline SHALL be carried alongside.
REQ-026 rd_data SHALL equal mem_data_out when the tagged address was <DEPTH, else 0; rd_data SHALL be 0 when no rvalid is asserted.
REQ-027 At most one rvalid SHALL be high per cycle; back-to-back grants SHALL yield back-to-back rvalids.
REQ-028 nn_lock rising during CLEAR SHALL NOT abort the sweep; the sweep SHALL complete.

Reset
REQ-029 resetn=0 SHALL immediately force state IDLE, count 0, pending 0, starvation 0, tag pipeline empty.
REQ-030 During reset, all grants, rvalids, mem_we, clear_busy, rd_data, addresses and mem_data_in SHALL be 0.
REQ-031 Reset mid-clear SHALL abort the sweep; the clear SHALL NOT resume after reset.

Structure
REQ-032 DEPTH, ADDR_W, DATA_W, STARVE_MAX, the clear-FSM state encodings and the requester-tag encodings SHALL live in the shared package image_mem_pkg.
REQ-033 Read arbitration plus starvation counter SHALL be one sub-module, image_rd_arbiter; the clear FSM and tag pipeline SHALL stay in the top module.

Verification
REQ-034 clear_req pulse from IDLE -> clear_busy=1 for exactly 784 cycles; mem_we=1 at addresses 0..783, data 0; wr_gnt=0 throughout.
REQ-035 wr_req, addr 57, data 1 in IDLE -> wr_gnt same cycle; next cycle mem_we=1, addr 57, data 1; addr 800 -> wr_gnt=1, mem_we=0.
REQ-036 nn_req and disp_req held continuously -> pattern 4 nn grants then 1 disp grant, repeating; each rvalid lands 2 cycles after its grant.
REQ-037 nn_lock=1 plus clear_req pulse -> no sweep and wr_gnt=0; nn_lock falls -> sweep starts next cycle.
REQ-038 Memory preloaded 5 at addr 10; nn_req addr 10 -> nn_rvalid=1 with rd_data=5 two cycles later; nn_addr 900 -> rd_data=0.
REQ-039 resetn low at count 300 mid-clear -> all outputs 0 immediately; after release, clear_busy stays 0 with no new clear_req.
